// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC sequencer with circular return-address stack
// Optional retired-cycle counter compiled in with PERF_COUNT_EN.
module pc_sequencer #(
  parameter int              PC_W      = 8,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              CNT_W     = 16
) (
  input  logic            clock,
  input  logic            reset_n_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic            call_i,
  input  logic            ret_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o,
  output logic            ras_empty_o,
  output logic            ras_full_o,
  output logic            ras_err_o
`ifdef PERF_COUNT_EN
  ,
  output logic [CNT_W-1:0] retired_o
`endif
);

  localparam int             PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(RAS_DEPTH);

  logic [PC_W-1:0]  r_pc;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   r_cnt;
  logic             r_err;
  logic [PC_W-1:0]  r_ras [RAS_DEPTH];

  logic [PC_W-1:0]  w_pc_inc;
  logic [PTR_W-1:0] w_ptr_dec;
  logic             w_empty;
  logic             w_full;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W:0]   w_cnt_nxt;
  logic             w_err_nxt;
  logic             w_push;

  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_ptr_dec = r_ptr - PTR_W'(1);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == FULL_CNT);

  // One action per cycle: stall > ret > call > branch > sequential.
  always_comb begin
    w_pc_nxt  = r_pc;
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    w_err_nxt = r_err;
    w_push    = 1'b0;
    if (!stall_i) begin
      if (ret_i) begin
        if (w_empty) begin
          w_pc_nxt  = w_pc_inc;
          w_err_nxt = 1'b1;
        end else begin
          w_pc_nxt  = r_ras[w_ptr_dec];
          w_ptr_nxt = w_ptr_dec;
          w_cnt_nxt = r_cnt - (PTR_W+1)'(1);
        end
      end else if (call_i) begin
        w_push    = 1'b1;
        w_ptr_nxt = r_ptr + PTR_W'(1);
        w_pc_nxt  = target_i;
        // A full stack silently drops its oldest entry; only the flag records it.
        if (w_full) begin
          w_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + (PTR_W+1)'(1);
        end
      end else if (branch_i) begin
        w_pc_nxt = target_i;
      end else begin
        w_pc_nxt = w_pc_inc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_pc  <= RESET_PC;
      r_ptr <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_ptr <= w_ptr_nxt;
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end

  // Entry contents need no reset; count and pointer gate every read.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_ras[r_ptr] <= w_pc_inc;
    end
  end

`ifdef PERF_COUNT_EN
  logic [CNT_W-1:0] r_retired;

  always_ff @(posedge clock or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_retired <= '0;
    end else if (!stall_i && (r_retired != '1)) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign retired_o = r_retired;
`endif

  assign pc_o        = r_pc;
  assign ras_empty_o = w_empty;
  assign ras_full_o  = w_full;
  assign ras_err_o   = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer against a queue-based model
// Retired-counter checks are compiled only with PERF_COUNT_EN (counter width 4).
module tb_pc_sequencer;

  localparam int DEPTH = 4;
`ifdef PERF_COUNT_EN
  localparam int CW = 4;
`endif

  logic       clock = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       stall_i = 1'b0;
  logic       branch_i = 1'b0;
  logic       call_i = 1'b0;
  logic       ret_i = 1'b0;
  logic [7:0] target_i = '0;
  logic [7:0] pc_o;
  logic       ras_empty_o;
  logic       ras_full_o;
  logic       ras_err_o;
`ifdef PERF_COUNT_EN
  logic [CW-1:0] retired_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_pc;
  logic [7:0] m_stack[$];
  logic       m_err;
  int         m_ret;

  always #5 clock = ~clock;

`ifdef PERF_COUNT_EN
  pc_sequencer #(.PC_W(8), .RAS_DEPTH(DEPTH), .RESET_PC(8'h00), .CNT_W(CW)) dut (
`else
  pc_sequencer #(.PC_W(8), .RAS_DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
`endif
    .clock(clock), .reset_n_i(reset_n_i), .stall_i(stall_i), .branch_i(branch_i),
    .call_i(call_i), .ret_i(ret_i), .target_i(target_i), .pc_o(pc_o),
    .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o), .ras_err_o(ras_err_o)
`ifdef PERF_COUNT_EN
    , .retired_o(retired_o)
`endif
  );

  task automatic model_reset();
    m_pc = 8'h00;
    m_stack.delete();
    m_err = 1'b0;
    m_ret = 0;
  endtask

  // Applies one request to the model, then lets the DUT take the same edge.
  task automatic step(input logic st, input logic br, input logic ca, input logic re,
                      input logic [7:0] tgt);
    stall_i = st; branch_i = br; call_i = ca; ret_i = re; target_i = tgt;
    if (!st) begin
`ifdef PERF_COUNT_EN
      if (m_ret < (2**CW) - 1) m_ret++;
`endif
      if (re) begin
        if (m_stack.size() == 0) begin
          m_pc = m_pc + 8'd1;
          m_err = 1'b1;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end else if (ca) begin
        if (m_stack.size() == DEPTH) begin
          void'(m_stack.pop_front());
          m_err = 1'b1;
        end
        m_stack.push_back(m_pc + 8'd1);
        m_pc = tgt;
      end else if (br) begin
        m_pc = tgt;
      end else begin
        m_pc = m_pc + 8'd1;
      end
    end
    @(posedge clock);
    #1;
    stall_i = 1'b0; branch_i = 1'b0; call_i = 1'b0; ret_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    stall_i = 1'b0; branch_i = 1'b0; call_i = 1'b0; ret_i = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (pc_o !== 8'h00) begin n_bad++; $display("FAIL reset_pc got=%h exp=00", pc_o); end
    n_cmp++; if (ras_empty_o !== 1'b1) begin n_bad++; $display("FAIL reset_empty got=%b exp=1", ras_empty_o); end
    n_cmp++; if (ras_full_o !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b exp=0", ras_full_o); end
    n_cmp++; if (ras_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", ras_err_o); end
`ifdef PERF_COUNT_EN
    n_cmp++; if (retired_o !== '0) begin n_bad++; $display("FAIL reset_retired got=%0d exp=0", retired_o); end
`endif
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0, 8'h00);
      n_cmp++; if (pc_o !== 8'(i)) begin n_bad++; $display("FAIL seq_pc got=%h exp=%h", pc_o, 8'(i)); end
    end
    step(0, 1, 0, 0, 8'hFE);
    step(0, 0, 0, 0, 8'h00);
    n_cmp++; if (pc_o !== 8'hFF) begin n_bad++; $display("FAIL seq_ff got=%h exp=ff", pc_o); end
    step(0, 0, 0, 0, 8'h00);
    n_cmp++; if (pc_o !== 8'h00) begin n_bad++; $display("FAIL seq_wrap got=%h exp=00", pc_o); end
    step(0, 0, 1, 0, 8'h30);
    step(0, 0, 0, 1, 8'h00);
    n_cmp++; if (pc_o !== 8'h01) begin n_bad++; $display("FAIL wrap_ret got=%h exp=01", pc_o); end
  endtask

  task automatic test_call_ret();
    do_reset();
    step(0, 1, 0, 0, 8'h05);
    step(0, 0, 1, 0, 8'h40);
    n_cmp++; if (pc_o !== 8'h40) begin n_bad++; $display("FAIL call_pc got=%h exp=40", pc_o); end
    n_cmp++; if (ras_empty_o !== 1'b0) begin n_bad++; $display("FAIL call_empty got=%b exp=0", ras_empty_o); end
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    n_cmp++; if (pc_o !== 8'h42) begin n_bad++; $display("FAIL call_seq got=%h exp=42", pc_o); end
    step(0, 0, 0, 1, 8'h00);
    n_cmp++; if (pc_o !== 8'h06) begin n_bad++; $display("FAIL ret_pc got=%h exp=06", pc_o); end
    n_cmp++; if (ras_empty_o !== 1'b1) begin n_bad++; $display("FAIL ret_empty got=%b exp=1", ras_empty_o); end
  endtask

  task automatic test_ras_overflow();
    logic [7:0] exp_ret [4];
    exp_ret = '{8'h15, 8'h14, 8'h13, 8'h12};
    do_reset();
    step(0, 1, 0, 0, 8'h10);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 8'h11 + 8'(i));
      if (i == 3) begin
        n_cmp++; if (ras_full_o !== 1'b1) begin n_bad++; $display("FAIL ovf_full got=%b exp=1", ras_full_o); end
        n_cmp++; if (ras_err_o !== 1'b0) begin n_bad++; $display("FAIL ovf_err_early got=%b exp=0", ras_err_o); end
      end
    end
    n_cmp++; if (ras_err_o !== 1'b1) begin n_bad++; $display("FAIL ovf_err got=%b exp=1", ras_err_o); end
    n_cmp++; if (ras_full_o !== 1'b1) begin n_bad++; $display("FAIL ovf_full5 got=%b exp=1", ras_full_o); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 8'h00);
      n_cmp++; if (pc_o !== exp_ret[i]) begin n_bad++; $display("FAIL ovf_ret%0d got=%h exp=%h", i, pc_o, exp_ret[i]); end
    end
    n_cmp++; if (ras_empty_o !== 1'b1) begin n_bad++; $display("FAIL ovf_drained got=%b exp=1", ras_empty_o); end
  endtask

  task automatic test_ret_empty();
    do_reset();
    step(0, 1, 0, 0, 8'h09);
    step(0, 0, 0, 1, 8'h00);
    n_cmp++; if (pc_o !== 8'h0A) begin n_bad++; $display("FAIL uflow_pc got=%h exp=0a", pc_o); end
    n_cmp++; if (ras_err_o !== 1'b1) begin n_bad++; $display("FAIL uflow_err got=%b exp=1", ras_err_o); end
    n_cmp++; if (ras_empty_o !== 1'b1) begin n_bad++; $display("FAIL uflow_empty got=%b exp=1", ras_empty_o); end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h70);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'h00);
    n_cmp++; if (ras_err_o !== 1'b1) begin n_bad++; $display("FAIL uflow_sticky got=%b exp=1", ras_err_o); end
    do_reset();
    n_cmp++; if (ras_err_o !== 1'b0) begin n_bad++; $display("FAIL uflow_clear got=%b exp=0", ras_err_o); end
  endtask

  task automatic test_priority();
    do_reset();
    step(0, 1, 0, 0, 8'h20);
    step(0, 0, 1, 0, 8'h50);
    step(1, 1, 1, 1, 8'h77);
    n_cmp++; if (pc_o !== 8'h50) begin n_bad++; $display("FAIL prio_stall_pc got=%h exp=50", pc_o); end
`ifdef PERF_COUNT_EN
    n_cmp++; if (retired_o !== CW'(m_ret)) begin n_bad++; $display("FAIL prio_stall_ret got=%0d exp=%0d", retired_o, m_ret); end
`endif
    step(0, 1, 1, 1, 8'h77);
    n_cmp++; if (pc_o !== 8'h21) begin n_bad++; $display("FAIL prio_ret_pc got=%h exp=21", pc_o); end
    n_cmp++; if (ras_empty_o !== 1'b1) begin n_bad++; $display("FAIL prio_ret_empty got=%b exp=1", ras_empty_o); end
    step(0, 1, 1, 0, 8'h66);
    n_cmp++; if (pc_o !== 8'h66) begin n_bad++; $display("FAIL prio_call_pc got=%h exp=66", pc_o); end
    n_cmp++; if (ras_empty_o !== 1'b0) begin n_bad++; $display("FAIL prio_call_push got=%b exp=0", ras_empty_o); end
  endtask

`ifdef PERF_COUNT_EN
  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 8'h00);
    n_cmp++; if (retired_o !== 4'd15) begin n_bad++; $display("FAIL sat_retired got=%0d exp=15", retired_o); end
  endtask
`endif

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'(i * 16 + 3));
    #2;
    reset_n_i = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (pc_o !== 8'h00) begin n_bad++; $display("FAIL async_pc got=%h exp=00", pc_o); end
    n_cmp++; if (ras_empty_o !== 1'b1) begin n_bad++; $display("FAIL async_empty got=%b exp=1", ras_empty_o); end
`ifdef PERF_COUNT_EN
    n_cmp++; if (retired_o !== '0) begin n_bad++; $display("FAIL async_retired got=%0d exp=0", retired_o); end
`endif
    #1;
    reset_n_i = 1'b1;
    step(0, 0, 0, 0, 8'h00);
    n_cmp++; if (pc_o !== 8'h01) begin n_bad++; $display("FAIL async_first got=%h exp=01", pc_o); end
  endtask

  task automatic test_random();
    logic st, br, ca, re;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 99) < 15);
      re = ($urandom_range(0, 99) < 30);
      ca = ($urandom_range(0, 99) < 35);
      br = ($urandom_range(0, 99) < 30);
      step(st, br, ca, re, 8'($urandom));
      n_cmp++; if (pc_o !== m_pc) begin n_bad++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, pc_o, m_pc); end
      n_cmp++; if (ras_empty_o !== (m_stack.size() == 0)) begin n_bad++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%0d", i, ras_empty_o, m_stack.size()); end
      n_cmp++; if (ras_full_o !== (m_stack.size() == DEPTH)) begin n_bad++; $display("FAIL rnd_full cyc=%0d got=%b depth=%0d", i, ras_full_o, m_stack.size()); end
      n_cmp++; if (ras_err_o !== m_err) begin n_bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, ras_err_o, m_err); end
`ifdef PERF_COUNT_EN
      n_cmp++; if (retired_o !== CW'(m_ret)) begin n_bad++; $display("FAIL rnd_retired cyc=%0d got=%0d exp=%0d", i, retired_o, m_ret); end
`endif
    end
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    test_sequential();
    test_call_ret();
    test_ras_overflow();
    test_ret_empty();
    test_priority();
`ifdef PERF_COUNT_EN
    test_saturation();
`endif
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the fetch stage of the pipelined core. It holds the current PC and selects the next value each cycle from stall, return, call, branch or sequential increment. A circular return-address stack (RAS) serves call/return. An optional retired-instruction counter can be compiled in for performance measurement.

## Interface
- PC_W, 8: PC width in bits.
- RAS_DEPTH, 4: number of return-address entries; a power of two, ≥2.
- RESET_PC, 0: PC value loaded on reset; PC_W bits wide.
- CNT_W, 16: width of the retired counter. Only used when PERF_COUNT_EN is defined.

- clock  in  1  rising-edge clock.
- reset_n_i  in  1  asynchronous active-low reset.
- stall_i  in  1  freezes the PC, the RAS and the counter.
- branch_i  in  1  loads target_i into the PC.
- call_i  in  1  pushes pc_o+1 onto the RAS and loads target_i.
- ret_i  in  1  pops the RAS and loads the popped address.
- target_i  in  PC_W  branch/call destination.
- pc_o  out  PC_W  current PC; driven directly from a register.
- ras_empty_o  out  1  RAS holds 0 entries.
- ras_full_o  out  1  RAS holds RAS_DEPTH entries.
- ras_err_o  out  1  sticky flag set by RAS overflow or underflow.
- retired_o  out  CNT_W  count of cycles in which the PC advanced. Present only with PERF_COUNT_EN.

## Operation
- **Reset** (while reset_n_i=0, asynchronous):
  - pc_o=RESET_PC.
  - RAS count=0 and pointer=0, so ras_empty_o=1 and ras_full_o=0.
  - ras_err_o=0, retired_o=0.
  - RAS entry contents are don't-care.
- **Next-PC priority**, evaluated each cycle (exactly one action is taken per cycle; lower-priority requests are ignored):
  1. stall_i: hold all state.
  2. ret_i: PC ← top of stack; pointer−1; count−1.
  3. call_i: entry[pointer] ← pc_o+1; pointer+1; count+1 (saturates at RAS_DEPTH); PC ← target_i.
  4. branch_i: PC ← target_i.
  5. otherwise: PC ← pc_o+1.
- **Arithmetic:** pc_o+1 wraps modulo 2^PC_W. With PC_W=8, 8'hFF increments to 8'h00, and a call at 8'hFF pushes 8'h00.
- **RAS organisation:** circular. The pointer wraps modulo RAS_DEPTH; the top of stack is entry[pointer−1].
- **Call when full:** the push overwrites the oldest entry, count stays at RAS_DEPTH, and ras_err_o is set.
- **Return when empty:**
  - PC ← pc_o+1, as for sequential fetch.
  - Pointer and count are unchanged.
  - ras_err_o is set.
  - The cycle counts as an advance.
- **ras_err_o:** once set, it is cleared only by reset.
- **Advance definition:** any cycle with stall_i=0.

## Timing
- All actions take effect at the rising clock edge; pc_o shows the new value 1 cycle after the request is sampled.
- There is no combinational path from any input to any output.
- Flag timing:
  - ras_empty_o and ras_full_o are derived from the registered count, so they reflect the post-edge state in the same cycle as pc_o.
  - ras_err_o rises on the edge that performs the faulting call or return.
- Call followed by return on the next cycle: the return pops the address just pushed; no bypass is needed because the RAS is written at the edge.
- Reset asserted mid-operation: all state is cleared immediately, without waiting for a clock edge. Deassertion is sampled synchronously on the next edge, where the first fetch starts from RESET_PC.

## Configuration
- PERF_COUNT_EN defined:
  - retired_o is present and increments by 1 on every advance.
  - It saturates at 2^CNT_W−1 rather than wrapping.
  - It resets to 0.
- PERF_COUNT_EN undefined: the retired_o port, the counter register and the CNT_W logic are all removed. All other behaviour is identical.

## Test plan
- Reset, then 3 free-running cycles → pc_o runs 0,1,2,3; with PC_W=8 and PC at 8'hFE, the next two values are 8'hFF, then 8'h00.
- At pc_o=5, assert call_i with target_i=8'h40 → pc_o=8'h40; after 2 sequential cycles pc_o=8'h42; a ret_i then gives pc_o=6 and ras_empty_o=1.
- 5 calls from pc 0x10..0x14 with RAS_DEPTH=4 → ras_full_o=1 after the 4th call and ras_err_o=1 after the 5th. Four returns then yield the 5th, 4th, 3rd and 2nd return addresses; the oldest is lost.
- ret_i with an empty RAS at pc_o=9 → pc_o=10, ras_err_o=1; the flag stays 1 until reset_n_i=0.
- stall_i, ret_i, call_i and branch_i asserted together → pc_o and retired_o hold. Dropping stall_i leaves ret_i taking priority over call_i and branch_i.
- PERF_COUNT_EN with CNT_W=4: 20 unstalled cycles → retired_o=15 (saturated). An asynchronous reset pulse mid-cycle forces retired_o=0 and pc_o=RESET_PC before the next edge.
